// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map, LCR/LSR bit
// positions, TX state encoding and the parity helper.
package uart_pkg;

  localparam logic [2:0] ADDR_THR    = 3'd0;
  localparam logic [2:0] ADDR_LCR    = 3'd1;
  localparam logic [2:0] ADDR_DIV_LO = 3'd2;
  localparam logic [2:0] ADDR_DIV_HI = 3'd3;
  localparam logic [2:0] ADDR_IER    = 3'd4;
  localparam logic [2:0] ADDR_LSR    = 3'd5;
  localparam logic [2:0] ADDR_LEVEL  = 3'd6;

  localparam int unsigned LCR_STOP2 = 2;
  localparam int unsigned LCR_PEN   = 3;
  localparam int unsigned LCR_EVEN  = 4;

  localparam int unsigned LSR_FULL  = 0;
  localparam int unsigned LSR_EMPTY = 1;
  localparam int unsigned LSR_IDLE  = 2;
  localparam int unsigned LSR_OVF   = 3;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // len selects 5..8 data bits; only those bits take part in the parity.
  function automatic logic calc_parity(logic [7:0] data, logic [1:0] len, logic even);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - len);
    return even ? ^(data & mask) : ~^(data & mask);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-attached UART transmitter: register file, TX FIFO and serialiser with
// configurable length, parity and stop bits.
module wb_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ADDR_W      = 5,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [7:0]        wb_dat_i,
  output logic [7:0]        wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              int_o,
  output logic              stx_pad_o
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]  lcr_q, lcr_d, ier_q, ier_d, div_lo_q, div_lo_d, div_hi_q, div_hi_d;
  logic [7:0]  dat_q, dat_d, shift_q, shift_d, lsr, rd_data, fifo_data;
  logic        ovf_q, ovf_d, ack_q, ack_d, int_q, int_d, tx_q, tx_d;
  logic        stop2_q, stop2_d, pen_q, pen_d, par_q, par_d, stop_idx_q, stop_idx_d;
  logic [15:0] cnt_q, cnt_d, bit_div_q, bit_div_d;
  logic [2:0]  bit_q, bit_d, last_q, last_d, addr;
  tx_state_e   state_q, state_d;
  logic        access, push, pop, full, empty, tx_idle, bit_end, unused_bits;
  logic [CntW-1:0] level;

  uart_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .push_i (push),
    .data_i (wb_dat_i),
    .pop_i  (pop),
    .data_o (fifo_data),
    .full_o (full),
    .empty_o(empty),
    .count_o(level)
  );

  assign addr        = wb_addr_i[2:0];
  assign unused_bits = ^{wb_addr_i[ADDR_W-1:3], wb_sel_i[3:1]};
  assign tx_idle     = empty & (state_q == StIdle);
  assign bit_end     = (cnt_q == bit_div_q);

  always_comb begin
    lsr            = '0;
    lsr[LSR_FULL]  = full;
    lsr[LSR_EMPTY] = empty;
    lsr[LSR_IDLE]  = tx_idle;
    lsr[LSR_OVF]   = ovf_q;
  end

  // Bus side: every strobed cycle is acked, but only byte lane 0 has any effect.
  always_comb begin
    lcr_d    = lcr_q;
    ier_d    = ier_q;
    div_lo_d = div_lo_q;
    div_hi_d = div_hi_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    access   = wb_cyc_i & wb_stb_i & ~ack_q & wb_sel_i[0];
    ack_d    = wb_cyc_i & wb_stb_i & ~ack_q;
    case (addr)
      ADDR_LCR:    rd_data = lcr_q;
      ADDR_DIV_LO: rd_data = div_lo_q;
      ADDR_DIV_HI: rd_data = div_hi_q;
      ADDR_IER:    rd_data = ier_q;
      ADDR_LSR:    rd_data = lsr;
      ADDR_LEVEL:  rd_data = 8'(level);
      default:     rd_data = '0;
    endcase
    if (access && wb_we_i) begin
      case (addr)
        ADDR_THR: begin
          push = ~full;
          if (full) ovf_d = 1'b1;
        end
        ADDR_LCR:    lcr_d    = wb_dat_i;
        ADDR_DIV_LO: div_lo_d = wb_dat_i;
        ADDR_DIV_HI: div_hi_d = wb_dat_i;
        ADDR_IER:    ier_d    = wb_dat_i;
        default:     ;
      endcase
    end
    if (access && !wb_we_i && addr == ADDR_LSR) ovf_d = 1'b0;
    dat_d = (access && !wb_we_i) ? rd_data : '0;
    int_d = (ier_q[0] & tx_idle) | (ier_q[1] & (level < CntW'(FIFO_DEPTH / 2)));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + 16'd1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: if (bit_end) begin
        state_d = StData;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      StData: if (bit_end) begin
        if (bit_q == last_q) begin
          state_d    = pen_q ? StParity : StStop;
          tx_d       = pen_q ? par_q : 1'b1;
          stop_idx_d = 1'b0;
        end else begin
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
      StParity: if (bit_end) begin
        state_d    = StStop;
        tx_d       = 1'b1;
        stop_idx_d = 1'b0;
      end
      StStop: if (bit_end) begin
        if (stop2_q && !stop_idx_q) begin
          stop_idx_d = 1'b1;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = StStart;
          tx_d    = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Frame format and bit time are frozen when the byte leaves the FIFO.
    last_d    = last_q;
    stop2_d   = stop2_q;
    pen_d     = pen_q;
    par_d     = par_q;
    bit_div_d = bit_div_q;
    if (pop) begin
      shift_d   = fifo_data;
      last_d    = {1'b1, lcr_q[1:0]};
      stop2_d   = lcr_q[LCR_STOP2];
      pen_d     = lcr_q[LCR_PEN];
      par_d     = calc_parity(fifo_data, lcr_q[1:0], lcr_q[LCR_EVEN]);
      bit_div_d = {div_hi_q, div_lo_q};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lcr_q      <= 8'h03;
      ier_q      <= '0;
      div_lo_q   <= DEFAULT_DIV[7:0];
      div_hi_q   <= DEFAULT_DIV[15:8];
      dat_q      <= '0;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
      int_q      <= 1'b0;
      tx_q       <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_div_q  <= DEFAULT_DIV;
      shift_q    <= '0;
      bit_q      <= '0;
      last_q     <= 3'd7;
      stop2_q    <= 1'b0;
      pen_q      <= 1'b0;
      par_q      <= 1'b0;
      stop_idx_q <= 1'b0;
    end else begin
      lcr_q      <= lcr_d;
      ier_q      <= ier_d;
      div_lo_q   <= div_lo_d;
      div_hi_q   <= div_hi_d;
      dat_q      <= dat_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
      int_q      <= int_d;
      tx_q       <= tx_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_div_q  <= bit_div_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      stop2_q    <= stop2_d;
      pen_q      <= pen_d;
      par_q      <= par_d;
      stop_idx_q <= stop_idx_d;
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign int_o     = int_q;
  assign stx_pad_o = tx_q;

endmodule
